packet_input_arbiter: RTL and testbench

Packet-granular round-robin arbiter that shares the single packet_classification datapath between four AXI4-Stream receive queues. Each input is buffered in a small fallthrough FIFO. The arbiter grants one queue at a time and forwards that queue's whole packet, header beat through TLAST, before re-arbitrating. It sits between the per-port RX queues and the classification/lookup stage, and also provides per-queue enable and per-queue forwarded-packet counters.

---
 rtl/packet_input_arbiter_pkg.sv | 19 +
 rtl/fallthrough_small_fifo.sv | 65 ++++++
 rtl/packet_input_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_packet_input_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/packet_input_arbiter_pkg.sv
// Shared constants and types for the four-queue packet input arbiter.
package packet_input_arbiter_pkg;

  localparam int NUM_QUEUES   = 4;
  localparam int QUEUE_IDX_W  = 2;
  localparam int SRC_PORT_POS = 16;
  localparam int SRC_PORT_W   = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic                   found;
    logic [QUEUE_IDX_W-1:0] idx;
  } queue_sel_t;

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Small show-ahead FIFO: the head word is visible on dout while empty is low.
module fallthrough_small_fifo #(
  parameter int WIDTH          = 72,
  parameter int MAX_DEPTH_BITS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             nearly_full,
  output logic             empty
);

  localparam int DEPTH = 1 << MAX_DEPTH_BITS;
  localparam logic [MAX_DEPTH_BITS:0]   FULL_LEVEL = (MAX_DEPTH_BITS + 1)'(DEPTH);
  localparam logic [MAX_DEPTH_BITS:0]   NEAR_LEVEL = (MAX_DEPTH_BITS + 1)'(DEPTH - 1);
  localparam logic [MAX_DEPTH_BITS:0]   CNT_ONE    = (MAX_DEPTH_BITS + 1)'(1);
  localparam logic [MAX_DEPTH_BITS:0]   CNT_ZERO   = (MAX_DEPTH_BITS + 1)'(0);
  localparam logic [MAX_DEPTH_BITS-1:0] PTR_ONE    = MAX_DEPTH_BITS'(1);
  localparam logic [MAX_DEPTH_BITS-1:0] PTR_ZERO   = MAX_DEPTH_BITS'(0);

  logic [WIDTH-1:0]          mem_r [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr_r;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr_r;
  logic [MAX_DEPTH_BITS:0]   depth_r;
  logic                      do_wr_s;
  logic                      do_rd_s;

  assign do_wr_s     = wr_en && (depth_r != FULL_LEVEL);
  assign do_rd_s     = rd_en && (depth_r != CNT_ZERO);
  assign dout        = mem_r[rd_ptr_r];
  assign empty       = (depth_r == CNT_ZERO);
  assign nearly_full = (depth_r >= NEAR_LEVEL);

  // storage array, data words carry no reset
  always_ff @(posedge clk) begin
    if (do_wr_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      depth_r  <= CNT_ZERO;
    end else begin
      if (do_wr_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_rd_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({do_wr_s, do_rd_s})
        2'b10:   depth_r <= depth_r + CNT_ONE;
        2'b01:   depth_r <= depth_r - CNT_ONE;
        default: depth_r <= depth_r;
      endcase
    end
  end

endmodule

// File: rtl/packet_input_arbiter.sv
// Packet-granular round-robin arbiter merging four buffered AXI4-Stream queues
// onto one master stream, with per-queue enables and forwarded-packet counters.
module packet_input_arbiter
  import packet_input_arbiter_pkg::*;
#(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXI_DATA_WIDTH   = 32,
  parameter int FIFO_DEPTH_BITS      = 2
) (
  input  logic                              AXI_ACLK,
  input  logic                              AXI_RESET,

  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    S_AXIS_0_TDATA,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_0_TSTRB,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   S_AXIS_0_TUSER,
  input  logic                              S_AXIS_0_TVALID,
  output logic                              S_AXIS_0_TREADY,
  input  logic                              S_AXIS_0_TLAST,

  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    S_AXIS_1_TDATA,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_1_TSTRB,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   S_AXIS_1_TUSER,
  input  logic                              S_AXIS_1_TVALID,
  output logic                              S_AXIS_1_TREADY,
  input  logic                              S_AXIS_1_TLAST,

  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    S_AXIS_2_TDATA,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_2_TSTRB,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   S_AXIS_2_TUSER,
  input  logic                              S_AXIS_2_TVALID,
  output logic                              S_AXIS_2_TREADY,
  input  logic                              S_AXIS_2_TLAST,

  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    S_AXIS_3_TDATA,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_3_TSTRB,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   S_AXIS_3_TUSER,
  input  logic                              S_AXIS_3_TVALID,
  output logic                              S_AXIS_3_TREADY,
  input  logic                              S_AXIS_3_TLAST,

  output logic [C_M_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  M_AXIS_TSTRB,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
  output logic                              M_AXIS_TVALID,
  input  logic                              M_AXIS_TREADY,
  output logic                              M_AXIS_TLAST,

  input  logic [NUM_QUEUES-1:0]             queue_enable,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     pkt_count_0,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     pkt_count_1,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     pkt_count_2,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     pkt_count_3,
  output logic [QUEUE_IDX_W-1:0]            cur_queue
);

  localparam int DW     = C_M_AXIS_DATA_WIDTH;
  localparam int UW     = C_M_AXIS_TUSER_WIDTH;
  localparam int SW     = C_M_AXIS_DATA_WIDTH / 8;
  localparam int FIFO_W = DW + UW + SW + 1;
  localparam int CNT_W  = C_S_AXI_DATA_WIDTH;

  localparam logic [CNT_W-1:0]       CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]       CNT_ZERO  = CNT_W'(0);
  localparam logic [QUEUE_IDX_W-1:0] Q_FIRST   = QUEUE_IDX_W'(0);
  localparam logic [QUEUE_IDX_W-1:0] Q_LAST    = QUEUE_IDX_W'(NUM_QUEUES - 1);

  // First eligible queue after the last grant, so the last grant ranks lowest.
  function automatic queue_sel_t rr_select(input logic [QUEUE_IDX_W-1:0] last,
                                           input logic [NUM_QUEUES-1:0]  eligible);
    queue_sel_t             sel;
    logic [QUEUE_IDX_W-1:0] idx;
    sel.found = 1'b0;
    sel.idx   = last;
    for (int k = NUM_QUEUES; k >= 1; k--) begin
      idx = last + QUEUE_IDX_W'(k);
      if (eligible[idx]) begin
        sel.found = 1'b1;
        sel.idx   = idx;
      end
    end
    return sel;
  endfunction

  logic [FIFO_W-1:0]      fifo_din  [NUM_QUEUES];
  logic [FIFO_W-1:0]      fifo_dout [NUM_QUEUES];
  logic [NUM_QUEUES-1:0]  fifo_wr;
  logic [NUM_QUEUES-1:0]  fifo_rd;
  logic [NUM_QUEUES-1:0]  fifo_empty;
  logic [NUM_QUEUES-1:0]  fifo_nearly_full;
  logic [NUM_QUEUES-1:0]  s_valid;

  arb_state_t             state_r;
  arb_state_t             state_next_s;
  logic [QUEUE_IDX_W-1:0] grant_r;
  logic [QUEUE_IDX_W-1:0] grant_next_s;
  logic [QUEUE_IDX_W-1:0] last_grant_r;
  logic [QUEUE_IDX_W-1:0] last_grant_next_s;
  logic [CNT_W-1:0]       pkt_count_r [NUM_QUEUES];

  logic [FIFO_W-1:0]      head_s;
  logic                   beat_s;
  logic                   pkt_done_s;
  logic [NUM_QUEUES-1:0]  eligible_s;
  queue_sel_t             sel_s;

  assign fifo_din[0] = {S_AXIS_0_TLAST, S_AXIS_0_TUSER, S_AXIS_0_TSTRB, S_AXIS_0_TDATA};
  assign fifo_din[1] = {S_AXIS_1_TLAST, S_AXIS_1_TUSER, S_AXIS_1_TSTRB, S_AXIS_1_TDATA};
  assign fifo_din[2] = {S_AXIS_2_TLAST, S_AXIS_2_TUSER, S_AXIS_2_TSTRB, S_AXIS_2_TDATA};
  assign fifo_din[3] = {S_AXIS_3_TLAST, S_AXIS_3_TUSER, S_AXIS_3_TSTRB, S_AXIS_3_TDATA};
  assign s_valid     = {S_AXIS_3_TVALID, S_AXIS_2_TVALID, S_AXIS_1_TVALID, S_AXIS_0_TVALID};

  assign S_AXIS_0_TREADY = ~fifo_nearly_full[0];
  assign S_AXIS_1_TREADY = ~fifo_nearly_full[1];
  assign S_AXIS_2_TREADY = ~fifo_nearly_full[2];
  assign S_AXIS_3_TREADY = ~fifo_nearly_full[3];

  // Input acceptance ignores grant and enable; only FIFO space throttles it.
  for (genvar q = 0; q < NUM_QUEUES; q++) begin : g_queue
    assign fifo_wr[q] = s_valid[q] & ~fifo_nearly_full[q];
    assign fifo_rd[q] = beat_s & (grant_r == QUEUE_IDX_W'(q));

    fallthrough_small_fifo #(
      .WIDTH          (FIFO_W),
      .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_fifo (
      .clk         (AXI_ACLK),
      .reset       (AXI_RESET),
      .din         (fifo_din[q]),
      .wr_en       (fifo_wr[q]),
      .rd_en       (fifo_rd[q]),
      .dout        (fifo_dout[q]),
      .nearly_full (fifo_nearly_full[q]),
      .empty       (fifo_empty[q])
    );
  end

  assign head_s        = fifo_dout[grant_r];
  assign M_AXIS_TDATA  = head_s[DW-1:0];
  assign M_AXIS_TSTRB  = head_s[DW +: SW];
  assign M_AXIS_TUSER  = head_s[DW + SW +: UW];
  assign M_AXIS_TLAST  = head_s[FIFO_W-1];
  assign M_AXIS_TVALID = (state_r == SEND) & ~fifo_empty[grant_r];
  assign beat_s        = M_AXIS_TVALID & M_AXIS_TREADY;
  assign pkt_done_s    = beat_s & M_AXIS_TLAST;
  assign eligible_s    = ~fifo_empty & queue_enable;
  assign sel_s         = rr_select(last_grant_r, eligible_s);

  assign cur_queue   = grant_r;
  assign pkt_count_0 = pkt_count_r[0];
  assign pkt_count_1 = pkt_count_r[1];
  assign pkt_count_2 = pkt_count_r[2];
  assign pkt_count_3 = pkt_count_r[3];

  // arbiter state, grant and rotation pointer
  always_ff @(posedge AXI_ACLK) begin
    if (AXI_RESET) begin
      state_r      <= IDLE;
      grant_r      <= Q_FIRST;
      last_grant_r <= Q_LAST;
    end else begin
      state_r      <= state_next_s;
      grant_r      <= grant_next_s;
      last_grant_r <= last_grant_next_s;
    end
  end

  // next-state: pick a queue in IDLE, hold the grant until TLAST leaves
  always_comb begin
    state_next_s      = state_r;
    grant_next_s      = grant_r;
    last_grant_next_s = last_grant_r;
    case (state_r)
      IDLE: begin
        if (sel_s.found) begin
          grant_next_s = sel_s.idx;
          state_next_s = SEND;
        end else begin
          state_next_s = IDLE;
        end
      end
      SEND: begin
        if (pkt_done_s) begin
          last_grant_next_s = grant_r;
          state_next_s      = IDLE;
        end else begin
          state_next_s = SEND;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // forwarded-packet counters, wrapping at full width
  always_ff @(posedge AXI_ACLK) begin
    for (int q = 0; q < NUM_QUEUES; q++) begin
      if (AXI_RESET) begin
        pkt_count_r[q] <= CNT_ZERO;
      end else if (pkt_done_s && (grant_r == QUEUE_IDX_W'(q))) begin
        pkt_count_r[q] <= pkt_count_r[q] + CNT_ONE;
      end else begin
        pkt_count_r[q] <= pkt_count_r[q];
      end
    end
  end

endmodule

// File: tb/tb_packet_input_arbiter.sv
// Directed-sequence bench with random payloads, checked against a packet-level
// round-robin scoreboard.
module tb_packet_input_arbiter;
  import packet_input_arbiter_pkg::*;

  typedef struct packed {
    logic         last;
    logic [127:0] user;
    logic [31:0]  strb;
    logic [255:0] data;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] s_tdata [4];
  logic [31:0]  s_tstrb [4];
  logic [127:0] s_tuser [4];
  logic [3:0]   s_tvalid;
  logic [3:0]   s_tlast;
  logic [3:0]   s_tready;
  logic [255:0] m_tdata;
  logic [31:0]  m_tstrb;
  logic [127:0] m_tuser;
  logic         m_tvalid;
  logic         m_tready;
  logic         m_tlast;
  logic [3:0]   queue_enable;
  logic [31:0]  pkt_count [4];
  logic [1:0]   cur_queue;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  beat_t sb [4][$];
  int    cnt_exp [4];
  int    model_last = 3;
  int    cur_src = 0;
  bit    in_pkt = 1'b0;
  bit    abort = 1'b0;
  logic [3:0] drv_busy = 4'b0000;
  int    out_cyc_q [$];
  int    in_cyc_q [$];
  int    out_src_q [$];

  always #5 clk = ~clk;

  packet_input_arbiter dut (
    .AXI_ACLK(clk), .AXI_RESET(rst),
    .S_AXIS_0_TDATA(s_tdata[0]), .S_AXIS_0_TSTRB(s_tstrb[0]), .S_AXIS_0_TUSER(s_tuser[0]),
    .S_AXIS_0_TVALID(s_tvalid[0]), .S_AXIS_0_TREADY(s_tready[0]), .S_AXIS_0_TLAST(s_tlast[0]),
    .S_AXIS_1_TDATA(s_tdata[1]), .S_AXIS_1_TSTRB(s_tstrb[1]), .S_AXIS_1_TUSER(s_tuser[1]),
    .S_AXIS_1_TVALID(s_tvalid[1]), .S_AXIS_1_TREADY(s_tready[1]), .S_AXIS_1_TLAST(s_tlast[1]),
    .S_AXIS_2_TDATA(s_tdata[2]), .S_AXIS_2_TSTRB(s_tstrb[2]), .S_AXIS_2_TUSER(s_tuser[2]),
    .S_AXIS_2_TVALID(s_tvalid[2]), .S_AXIS_2_TREADY(s_tready[2]), .S_AXIS_2_TLAST(s_tlast[2]),
    .S_AXIS_3_TDATA(s_tdata[3]), .S_AXIS_3_TSTRB(s_tstrb[3]), .S_AXIS_3_TUSER(s_tuser[3]),
    .S_AXIS_3_TVALID(s_tvalid[3]), .S_AXIS_3_TREADY(s_tready[3]), .S_AXIS_3_TLAST(s_tlast[3]),
    .M_AXIS_TDATA(m_tdata), .M_AXIS_TSTRB(m_tstrb), .M_AXIS_TUSER(m_tuser),
    .M_AXIS_TVALID(m_tvalid), .M_AXIS_TREADY(m_tready), .M_AXIS_TLAST(m_tlast),
    .queue_enable(queue_enable),
    .pkt_count_0(pkt_count[0]), .pkt_count_1(pkt_count[1]),
    .pkt_count_2(pkt_count[2]), .pkt_count_3(pkt_count[3]),
    .cur_queue(cur_queue)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Round robin: first pending queue after the last one served, modulo 4.
  function automatic int rr_pick(input int last, input logic [3:0] pending);
    for (int k = 1; k <= 4; k++) begin
      if (pending[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  function automatic int sb_total();
    int t = 0;
    for (int q = 0; q < 4; q++) t += sb[q].size();
    return t;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: transfers are sampled half a cycle before the edge that completes them.
  always @(negedge clk) begin
    logic [3:0] pending;
    int         exp_src;
    beat_t      exp_b;
    if (rst) begin
      for (int q = 0; q < 4; q++) begin
        sb[q].delete();
        cnt_exp[q] = 0;
      end
      in_pkt = 1'b0;
      model_last = 3;
    end else begin
      for (int q = 0; q < 4; q++) pending[q] = (sb[q].size() != 0) && queue_enable[q];
      for (int q = 0; q < 4; q++) begin
        if (s_tvalid[q] && s_tready[q]) begin
          sb[q].push_back({s_tlast[q], s_tuser[q], s_tstrb[q], s_tdata[q]});
          in_cyc_q.push_back(cyc);
        end
      end
      if (m_tvalid && m_tready) begin
        out_cyc_q.push_back(cyc);
        if (!in_pkt) begin
          exp_src = rr_pick(model_last, pending);
          out_src_q.push_back(int'(m_tuser[SRC_PORT_POS +: SRC_PORT_W]));
          check("grant_expected", 256'(exp_src >= 0), 256'(1));
          if (exp_src >= 0) begin
            check("cur_queue", 256'(cur_queue), 256'(exp_src));
            cur_src = exp_src;
          end else begin
            cur_src = int'(cur_queue);
          end
          in_pkt = 1'b1;
        end
        check("beat_available", 256'(sb[cur_src].size() != 0), 256'(1));
        if (sb[cur_src].size() != 0) begin
          exp_b = sb[cur_src].pop_front();
          check("tdata", m_tdata, exp_b.data);
          check("tstrb", 256'(m_tstrb), 256'(exp_b.strb));
          check("tuser", 256'(m_tuser), 256'(exp_b.user));
          check("tlast", 256'(m_tlast), 256'(exp_b.last));
          if (exp_b.last) begin
            cnt_exp[cur_src]++;
            model_last = cur_src;
            in_pkt = 1'b0;
          end
        end
      end
    end
  end

  task automatic drive_pkt(input int q, input int nbeats);
    bit acc;
    bit timed_out;
    int guard;
    drv_busy[q] = 1'b1;
    timed_out = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      if (abort) break;
      for (int w = 0; w < 8; w++) s_tdata[q][32*w +: 32] = $urandom();
      for (int w = 0; w < 4; w++) s_tuser[q][32*w +: 32] = $urandom();
      s_tuser[q][SRC_PORT_POS +: SRC_PORT_W] = 8'(q);
      s_tstrb[q]  = $urandom();
      s_tlast[q]  = (b == nbeats - 1);
      s_tvalid[q] = 1'b1;
      acc   = 1'b0;
      guard = 0;
      while (!acc) begin
        @(negedge clk);
        acc = s_tready[q];
        @(posedge clk);
        #1;
        if (abort) break;
        guard++;
        if (!acc && guard >= 500) begin
          check("input_accept_timeout", 256'(acc), 256'(1));
          timed_out = 1'b1;
          break;
        end
      end
      if (timed_out || abort) break;
    end
    s_tvalid[q] = 1'b0;
    s_tlast[q]  = 1'b0;
    drv_busy[q] = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    int n = 0;
    while ((drv_busy != 4'b0000 || in_pkt || sb_total() != 0) && n < bound) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_timeout", 256'(n < bound), 256'(1));
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_counts(input string tag);
    for (int q = 0; q < 4; q++) check(tag, 256'(pkt_count[q]), 256'(cnt_exp[q]));
  endtask

  task automatic clear_logs();
    out_cyc_q.delete();
    in_cyc_q.delete();
    out_src_q.delete();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int   n;
    int   c1;
    rst = 1'b1;
    s_tvalid = 4'b0000;
    s_tlast = 4'b0000;
    for (int q = 0; q < 4; q++) begin
      s_tdata[q] = 256'd0;
      s_tstrb[q] = 32'd0;
      s_tuser[q] = 128'd0;
    end
    m_tready = 1'b1;
    queue_enable = 4'b1111;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tvalid", 256'(m_tvalid), 256'(0));
    check("reset_cur_queue", 256'(cur_queue), 256'(0));
    for (int q = 0; q < 4; q++) check("reset_count", 256'(pkt_count[q]), 256'(0));
    rst = 1'b0;

    // Single 3-beat packet on queue 0
    clear_logs();
    drive_pkt(0, 3);
    wait_drain(200);
    check("t1_beats", 256'(out_cyc_q.size()), 256'(3));
    if (out_cyc_q.size() >= 1 && in_cyc_q.size() >= 1)
      check("t1_latency", 256'(out_cyc_q[0] - in_cyc_q[0]), 256'(2));
    check("t1_count0", 256'(pkt_count[0]), 256'(1));
    check("t1_cur_queue", 256'(cur_queue), 256'(0));

    // Simultaneous single-beat packets on queues 0, 1, 3 from reset
    do_reset(2);
    clear_logs();
    fork
      drive_pkt(0, 1);
      drive_pkt(1, 1);
      drive_pkt(3, 1);
    join
    wait_drain(200);
    check("t2_npkts", 256'(out_src_q.size()), 256'(3));
    if (out_src_q.size() == 3) begin
      check("t2_order0", 256'(out_src_q[0]), 256'(0));
      check("t2_order1", 256'(out_src_q[1]), 256'(1));
      check("t2_order2", 256'(out_src_q[2]), 256'(3));
      check("t2_gap01", 256'(out_cyc_q[1] - out_cyc_q[0]), 256'(2));
      check("t2_gap12", 256'(out_cyc_q[2] - out_cyc_q[1]), 256'(2));
    end
    check("t2_count0", 256'(pkt_count[0]), 256'(1));
    check("t2_count1", 256'(pkt_count[1]), 256'(1));
    check("t2_count2", 256'(pkt_count[2]), 256'(0));
    check("t2_count3", 256'(pkt_count[3]), 256'(1));

    // Wrap from last grant 3: queue 0 before queue 2
    clear_logs();
    fork
      drive_pkt(0, 1);
      drive_pkt(2, 1);
    join
    wait_drain(200);
    check("t3_npkts", 256'(out_src_q.size()), 256'(2));
    if (out_src_q.size() == 2) begin
      check("t3_first", 256'(out_src_q[0]), 256'(0));
      check("t3_second", 256'(out_src_q[1]), 256'(2));
    end
    check_counts("t3_counts");

    // 4-beat queue 2 packet with toggling ready, queue 1 arriving mid-packet
    clear_logs();
    fork
      drive_pkt(2, 4);
      begin
        repeat (3) @(posedge clk);
        #1;
        drive_pkt(1, 2);
      end
      begin
        for (int i = 0; i < 40; i++) begin
          @(posedge clk);
          #1;
          m_tready = ~m_tready;
        end
        m_tready = 1'b1;
      end
    join
    wait_drain(300);
    check("t4_beats", 256'(out_cyc_q.size()), 256'(6));
    check("t4_npkts", 256'(out_src_q.size()), 256'(2));
    if (out_src_q.size() == 2) begin
      check("t4_first", 256'(out_src_q[0]), 256'(2));
      check("t4_second", 256'(out_src_q[1]), 256'(1));
    end
    check_counts("t4_counts");

    // Queue 1 disabled: only queue 2 forwarded, queue 1 backs up
    clear_logs();
    queue_enable = 4'b1101;
    c1 = int'(pkt_count[1]);
    fork
      drive_pkt(1, 5);
    join_none
    drive_pkt(2, 2);
    n = 0;
    while (out_cyc_q.size() < 2 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (6) @(posedge clk);
    #1;
    check("t5_q2_only", 256'(out_cyc_q.size()), 256'(2));
    check("t5_tready1_low", 256'(s_tready[1]), 256'(0));
    check("t5_count1_hold", 256'(pkt_count[1]), 256'(c1));
    queue_enable = 4'b1111;
    wait_drain(300);
    check("t5_count1_inc", 256'(pkt_count[1]), 256'(c1 + 1));
    if (out_src_q.size() == 2) check("t5_second_src", 256'(out_src_q[1]), 256'(1));
    check_counts("t5_counts");

    // Reset during beat 2 of a 5-beat packet, then a fresh packet on queue 3
    clear_logs();
    fork
      drive_pkt(0, 5);
    join_none
    n = 0;
    while (out_cyc_q.size() < 1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    rst = 1'b1;
    abort = 1'b1;
    s_tvalid = 4'b0000;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t6_tvalid_after_reset", 256'(m_tvalid), 256'(0));
    for (int q = 0; q < 4; q++) check("t6_count_cleared", 256'(pkt_count[q]), 256'(0));
    n = 0;
    while (drv_busy != 4'b0000 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    abort = 1'b0;
    clear_logs();
    drive_pkt(3, 2);
    wait_drain(200);
    check("t6_count3", 256'(pkt_count[3]), 256'(1));
    check("t6_count0", 256'(pkt_count[0]), 256'(0));
    check("t6_beats", 256'(out_cyc_q.size()), 256'(2));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
